// File: rtl/alu_pkg.sv
// mc_alu shared types: op codes, FSM states, flag bundle.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_PASSB = 4'b0000,
    OP_ADD   = 4'b0010,
    OP_SUB   = 4'b0011,
    OP_AND   = 4'b0100,
    OP_OR    = 4'b0101,
    OP_XOR   = 4'b0110,
    OP_MUL   = 4'b1000,
    OP_LSL   = 4'b1001,
    OP_LSR   = 4'b1010
  } alu_op_e;

  typedef enum logic {
    IDLE = 1'b0,
    MUL  = 1'b1
  } mc_alu_state_e;

  typedef struct packed {
    logic zero;
    logic negative;
    logic overflow;
    logic carry_out;
  } alu_flags_t;

endpackage

// File: rtl/alu_iter_mul.sv
// Iterative shift-add unsigned multiplier, one multiplier bit per cycle.
// done pulses on the last iteration with product carrying that iteration's sum.
module alu_iter_mul #(
  parameter int WIDTH = 64
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic               abort,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH) + 1;

  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [2*WIDTH-1:0] addend;
  logic [2*WIDTH-1:0] sum;

  always_comb begin
    addend   = mplier_q[0] ? mcand_q : '0;
    sum      = acc_q + addend;
    done     = (cnt_q == CW'(1));
    product  = sum;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    if (abort) begin
      cnt_d = '0;
    end else if (start) begin
      cnt_d    = CW'(WIDTH);
      acc_d    = '0;
      mcand_d  = {{WIDTH{1'b0}}, a};
      mplier_d = b;
    end else if (cnt_q != '0) begin
      cnt_d    = cnt_q - CW'(1);
      acc_d    = sum;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
    end else begin
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
    end
  end

endmodule

// File: rtl/mc_alu.sv
// Multi-cycle EX-stage ALU: single-cycle core plus iterative MUL,
// registered result/flags behind a valid/ready handshake.
module mc_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             negative,
  output logic             overflow,
  output logic             carry_out
);

  localparam int SHW = $clog2(WIDTH);

  mc_alu_state_e    state_q, state_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] res_q, res_d;
  alu_flags_t       flags_q, flags_d;

  logic [WIDTH:0]     add_w, sub_w;
  logic [SHW-1:0]     shamt;
  logic [WIDTH-1:0]   core_res;
  alu_flags_t         core_flags;
  logic               accept;
  logic               mul_start;
  logic               mul_done;
  logic [2*WIDTH-1:0] mul_prod;

  always_comb begin
    add_w = {1'b0, a} + {1'b0, b};
    sub_w = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
    shamt = b[SHW-1:0];
    core_res   = '0;
    core_flags = '0;
    unique case (op)
      OP_PASSB: core_res = b;
      OP_ADD: begin
        core_res = add_w[WIDTH-1:0];
        core_flags.carry_out = add_w[WIDTH];
        // carry into MSB recovered from the MSB sum bit
        core_flags.overflow = a[WIDTH-1] ^ b[WIDTH-1]
                            ^ add_w[WIDTH-1] ^ add_w[WIDTH];
      end
      OP_SUB: begin
        core_res = sub_w[WIDTH-1:0];
        core_flags.carry_out = sub_w[WIDTH];
        core_flags.overflow = a[WIDTH-1] ^ ~b[WIDTH-1]
                            ^ sub_w[WIDTH-1] ^ sub_w[WIDTH];
      end
      OP_AND:  core_res = a & b;
      OP_OR:   core_res = a | b;
      OP_XOR:  core_res = a ^ b;
      OP_LSL:  core_res = a << shamt;
      OP_LSR:  core_res = a >> shamt;
      default: core_res = '0;
    endcase
    core_flags.zero     = (core_res == '0);
    core_flags.negative = core_res[WIDTH-1];
  end

  assign in_ready = (state_q == IDLE)
                 && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready && !flush;
  assign mul_start = accept && (op == OP_MUL);

  alu_iter_mul #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (mul_start),
    .abort   (flush),
    .a       (a),
    .b       (b),
    .done    (mul_done),
    .product (mul_prod)
  );

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q && !out_ready;
    res_d       = res_q;
    flags_d     = flags_q;
    if (flush) begin
      state_d     = IDLE;
      out_valid_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (mul_start) begin
            state_d = MUL;
          end else if (accept) begin
            res_d       = core_res;
            flags_d     = core_flags;
            out_valid_d = 1'b1;
          end
        end
        MUL: begin
          if (mul_done) begin
            res_d              = mul_prod[WIDTH-1:0];
            flags_d.zero       = (mul_prod[WIDTH-1:0] == '0);
            flags_d.negative   = mul_prod[WIDTH-1];
            flags_d.overflow   = 1'b0;
            flags_d.carry_out  = |mul_prod[2*WIDTH-1:WIDTH];
            out_valid_d        = 1'b1;
            state_d            = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      res_q       <= '0;
      flags_q     <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      res_q       <= res_d;
      flags_q     <= flags_d;
    end
  end

  assign out_valid = out_valid_q;
  assign result    = res_q;
  assign zero      = flags_q.zero;
  assign negative  = flags_q.negative;
  assign overflow  = flags_q.overflow;
  assign carry_out = flags_q.carry_out;

endmodule

// File: tb/tb_mc_alu.sv
// Bench for mc_alu: WIDTH=64 and WIDTH=8 instances against a reference model.
module tb_mc_alu;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid, flush, out_ready, sel;
  logic [3:0]  op;
  logic [63:0] a, b;

  logic        rdy64, vld64, z64, n64, v64, c64;
  logic [63:0] res64;
  logic        rdy8, vld8, z8, n8, v8, c8;
  logic [7:0]  res8;

  logic        o_ready, o_valid;
  logic [63:0] o_res;
  logic [3:0]  o_flags;

  int errs = 0;
  int checks = 0;

  logic [3:0] op_tab [10] = '{4'h0, 4'h2, 4'h3, 4'h4, 4'h5,
                              4'h6, 4'h8, 4'h9, 4'hA, 4'h7};

  always #5 clk = ~clk;

  mc_alu #(.WIDTH(64)) u64 (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid && !sel), .in_ready(rdy64),
    .op(op), .a(a), .b(b), .flush(flush),
    .out_valid(vld64), .out_ready(out_ready),
    .result(res64), .zero(z64), .negative(n64),
    .overflow(v64), .carry_out(c64)
  );

  mc_alu #(.WIDTH(8)) u8 (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid && sel), .in_ready(rdy8),
    .op(op), .a(a[7:0]), .b(b[7:0]), .flush(flush),
    .out_valid(vld8), .out_ready(out_ready),
    .result(res8), .zero(z8), .negative(n8),
    .overflow(v8), .carry_out(c8)
  );

  assign o_ready = sel ? rdy8 : rdy64;
  assign o_valid = sel ? vld8 : vld64;
  assign o_res   = sel ? {56'd0, res8} : res64;
  assign o_flags = sel ? {c8, v8, n8, z8} : {c64, v64, n64, z64};

  task automatic chk(input string tag, input logic [127:0] got,
                     input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // returns {carry, overflow, negative, zero, result}
  function automatic logic [67:0] model(input int w, input logic [3:0] o,
                                        input logic [63:0] ai,
                                        input logic [63:0] bi);
    logic [127:0] m, x, y, r, full;
    logic c, v;
    int sh;
    m = (128'd1 << w) - 128'd1;
    x = {64'd0, ai} & m;
    y = {64'd0, bi} & m;
    sh = int'(y[7:0]) % w;
    c = 1'b0;
    v = 1'b0;
    r = '0;
    case (o)
      4'h0: r = y;
      4'h2: begin
        full = x + y;
        r = full & m;
        c = full[w];
        v = (x[w-1] == y[w-1]) && (r[w-1] != x[w-1]);
      end
      4'h3: begin
        r = (x - y) & m;
        c = (x >= y);
        v = (x[w-1] != y[w-1]) && (r[w-1] != x[w-1]);
      end
      4'h4: r = x & y;
      4'h5: r = x | y;
      4'h6: r = x ^ y;
      4'h8: begin
        full = x * y;
        r = full & m;
        c = (full >> w) != 0;
      end
      4'h9: r = (x << sh) & m;
      4'hA: r = x >> sh;
      default: r = '0;
    endcase
    return {c, v, r[w-1], (r == 0), r[63:0]};
  endfunction

  task automatic start_op(input logic [3:0] op_i, input logic [63:0] a_i,
                          input logic [63:0] b_i, input string nm);
    int n = 0;
    while (!o_ready && n < 300) begin
      tick();
      n++;
    end
    chk({nm, "_rdy"}, o_ready, 1);
    op = op_i;
    a = a_i;
    b = b_i;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic run_op(input logic [3:0] op_i, input logic [63:0] a_i,
                        input logic [63:0] b_i, input string nm);
    logic [67:0] e;
    int w;
    w = sel ? 8 : 64;
    e = model(w, op_i, a_i, b_i);
    start_op(op_i, a_i, b_i, nm);
    if (op_i == 4'h8) begin
      for (int i = 0; i < w; i++) begin
        chk({nm, "_busy"}, {o_ready, o_valid}, 2'b00);
        tick();
      end
    end
    chk({nm, "_vld"}, o_valid, 1);
    chk({nm, "_res"}, o_res, e[63:0]);
    chk({nm, "_flg"}, o_flags, e[67:64]);
    chk({nm, "_irdy"}, o_ready, out_ready);
  endtask

  function automatic logic [63:0] rnd_val();
    logic [63:0] s [4] = '{64'd0, '1, 64'h8000_0000_0000_0000,
                           64'h7FFF_FFFF_FFFF_FFFF};
    if ($urandom_range(0, 3) == 0) return s[$urandom_range(0, 3)];
    return {$urandom, $urandom};
  endfunction

  initial begin
    logic [63:0] hold_r;
    logic [3:0]  hold_f;
    logic [3:0]  rop;
    logic        seen;

    reset_n = 1'b0;
    in_valid = 1'b0;
    flush = 1'b0;
    out_ready = 1'b1;
    sel = 1'b0;
    op = '0;
    a = '0;
    b = '0;

    #3;
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #1;
      chk("rst_rdy", o_ready, 1);
      chk("rst_vld", o_valid, 0);
      chk("rst_res", o_res, 0);
      chk("rst_flg", o_flags, 0);
    end
    sel = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    tick();

    run_op(4'h2, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, "add_ovf");
    chk("add_ovf_k", o_res, 64'h8000_0000_0000_0000);
    chk("add_ovf_kf", o_flags, 4'b0110);
    run_op(4'h3, 64'd5, 64'd5, "sub_eq");
    chk("sub_eq_k", {o_res, o_flags}, {64'd0, 4'b1001});
    run_op(4'hA, 64'hF0, 64'd68, "lsr");
    chk("lsr_k", o_res, 64'h0F);
    run_op(4'h9, 64'd1, 64'd63, "lsl");
    chk("lsl_k", o_res, 64'h8000_0000_0000_0000);
    run_op(4'h7, 64'h1234, 64'h5678, "ill");
    chk("ill_k", {o_res, o_flags}, {64'd0, 4'b0001});

    tick();
    out_ready = 1'b0;
    run_op(4'h2, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, "bp_add");
    hold_r = 64'd1;
    hold_f = 4'b1000;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_hold", {o_valid, o_ready, o_res, o_flags},
          {1'b1, 1'b0, hold_r, hold_f});
    end
    out_ready = 1'b1;
    #1;
    chk("bp_rel_rdy", o_ready, 1);
    run_op(4'h6, 64'hFF, 64'h0F, "bp_xor");
    chk("bp_xor_k", o_res, 64'hF0);

    flush = 1'b1;
    op = 4'h2;
    a = 64'd1;
    b = 64'd1;
    in_valid = 1'b1;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("fl_in", {o_valid, o_ready, o_res}, {1'b0, 1'b1, 64'hF0});

    for (int i = 0; i < 40; i++) begin
      rop = op_tab[$urandom_range(0, 9)];
      if ($urandom_range(0, 5) == 0) rop = 4'($urandom_range(0, 15));
      run_op(rop, rnd_val(), rnd_val(), "r64");
    end

    sel = 1'b1;
    tick();
    run_op(4'h8, 64'h10, 64'h10, "mul8a");
    chk("mul8a_k", {o_res, o_flags}, {64'h00, 4'b1001});
    run_op(4'h8, 64'h0D, 64'h0B, "mul8b");
    chk("mul8b_k", {o_res, o_flags}, {64'h8F, 4'b0010});

    start_op(4'h8, 64'hFF, 64'h03, "fl3");
    tick();
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("fl3_st", {o_ready, o_valid}, 2'b10);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      seen |= o_valid;
    end
    chk("fl3_novld", seen, 0);
    run_op(4'h2, 64'd2, 64'd3, "fl3_add");
    chk("fl3_add_k", {o_res, o_flags}, {64'd5, 4'b0000});

    start_op(4'h8, 64'h0D, 64'h0B, "flend");
    for (int i = 0; i < 7; i++) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flend_st", {o_ready, o_valid, o_res}, {1'b1, 1'b0, 64'd5});
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      seen |= o_valid;
    end
    chk("flend_novld", seen, 0);

    for (int i = 0; i < 40; i++) begin
      rop = op_tab[$urandom_range(0, 9)];
      if ($urandom_range(0, 5) == 0) rop = 4'($urandom_range(0, 15));
      run_op(rop, rnd_val(), rnd_val(), "r8");
    end
    run_op(4'h2, 64'h7F, 64'h01, "add8");
    chk("add8_k", {o_res, o_flags}, {64'h80, 4'b0110});

    start_op(4'h8, 64'hFF, 64'hFF, "rstm");
    tick();
    tick();
    tick();
    #2;
    reset_n = 1'b0;
    #1;
    chk("rstm_out", {o_ready, o_valid, o_res, o_flags},
        {1'b1, 1'b0, 64'd0, 4'd0});
    @(negedge clk);
    reset_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      seen |= o_valid;
    end
    chk("rstm_after", {o_ready, seen}, 2'b10);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
